// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO/RAM controller slice.
package fifo_pkg;

  localparam int RAM_AW_MAX = 16;
  localparam int RAM_DW_MAX = 64;

  // Generic RAM port request, sized for the widest RAM in the subsystem.
  typedef struct packed {
    logic                  we;
    logic [RAM_AW_MAX-1:0] addr;
    logic [RAM_DW_MAX-1:0] data;
  } ram_req_t;

  function automatic int clog2(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry FWFT output buffer; absorbs the RAM read latency so reads can
// be issued ahead of the consumer.
module fifo_out_buf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cap,
  input  logic [DATA_WIDTH-1:0] cap_data,
  input  logic                  pop,
  output logic [1:0]            out_cnt,
  output logic [DATA_WIDTH-1:0] head
);

  logic [1:0][DATA_WIDTH-1:0] ent;
  logic [1:0]                 tail;

  // Slot the captured word lands in, after this cycle's pop has shifted.
  assign tail = out_cnt - {1'b0, pop};
  assign head = ent[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent     <= '0;
      out_cnt <= '0;
    end else begin
      if (pop) ent[0] <= ent[1];
      if (cap) ent[tail[0]] <= cap_data;
      out_cnt <= out_cnt - {1'b0, pop} + {1'b0, cap};
    end
  end

endmodule

// File: rtl/sync_fifo_ram_ctrl.sv
// Single-clock FIFO controller driving an external simple dual-port RAM
// with registered read data; first-word-fall-through consumer side.
module sync_fifo_ram_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 16,
  parameter int ADDR_WIDTH   = clog2(DEPTH),
  parameter int CNT_WIDTH    = clog2(DEPTH + 3),
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  almost_full
);

  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic                  inflight;
  logic [1:0]            out_cnt;
  logic [1:0]            occ;
  logic                  push, pop;
  logic [CNT_WIDTH-1:0]  count_n;

  assign wr_ready  = (ram_cnt != (ADDR_WIDTH+1)'(DEPTH));
  assign push      = wr_valid & wr_ready;
  assign rd_valid  = (out_cnt != 2'd0);
  assign pop       = rd_valid & rd_ready;

  assign ram_we    = push;
  assign ram_waddr = wptr;
  assign ram_wdata = wr_data;

  // Buffer slots spoken for next cycle; pop implies out_cnt >= 1, so no underflow.
  assign occ       = out_cnt + {1'b0, inflight} - {1'b0, pop};
  assign ram_re    = (ram_cnt != '0) && (occ < 2'd2);
  assign ram_raddr = rptr;

  assign count_n   = count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      ram_cnt     <= '0;
      inflight    <= 1'b0;
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      if (push)   wptr <= wptr + ADDR_WIDTH'(1);
      if (ram_re) rptr <= rptr + ADDR_WIDTH'(1);
      ram_cnt     <= ram_cnt + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(ram_re);
      inflight    <= ram_re;
      count       <= count_n;
      almost_full <= (count_n >= CNT_WIDTH'(AFULL_THRESH));
    end
  end

  fifo_out_buf #(.DATA_WIDTH(DATA_WIDTH)) u_out_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .cap      (inflight),
    .cap_data (ram_rdata),
    .pop      (pop),
    .out_cnt  (out_cnt),
    .head     (rd_data)
  );

endmodule

// File: tb/tb_sync_fifo_ram_ctrl.sv
// Bench for sync_fifo_ram_ctrl with a behavioural RAM and a queue scoreboard.
module tb_sync_fifo_ram_ctrl;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [DW-1:0] rd_data;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic [CW-1:0] count;
  logic          almost_full;

  always #5 clk = ~clk;

  sync_fifo_ram_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .count(count), .almost_full(almost_full)
  );

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_raddr];
  end

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] q[$];
  int            pushes_n = 0;
  int            pops_n = 0;
  bit            stall_prev = 0;
  logic [DW-1:0] prev_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard the handshakes at negedge, then check registered state.
  task automatic tick();
    @(negedge clk);
    if (stall_prev) begin
      chk("stall_valid", rd_valid, 1);
      chk("stall_data", rd_data, prev_data);
    end
    if (ram_we && ram_re) chk("addr_conflict", ram_waddr != ram_raddr, 1);
    if (rd_valid && rd_ready) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $error("FAIL pop_underflow observed=%0h expected=no_data", rd_data);
      end else chk("pop_data", rd_data, q.pop_front());
      pops_n++;
    end
    if (wr_valid && wr_ready) begin
      q.push_back(wr_data);
      pushes_n++;
    end
    stall_prev = rd_valid && !rd_ready;
    prev_data  = rd_data;
    @(posedge clk); #1;
    chk("count", count, q.size());
    chk("almost_full", almost_full, q.size() >= 2);
  endtask

  initial begin
    int cyc, push_target, pop_target;
    bit got;
    rst_n = 0; wr_valid = 0; wr_data = '0; rd_ready = 0;
    void'($urandom(1));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_count", count, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_re", ram_re, 0);
    rst_n = 1;

    // idle after reset
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("idle_ram_re", ram_re, 0);
      chk("idle_rd_valid", rd_valid, 0);
      chk("idle_wr_ready", wr_ready, 1);
      tick();
    end

    // single word latency
    wr_valid = 1; wr_data = 32'hA1; #1;
    chk("lat_ram_we", ram_we, 1);
    chk("lat_waddr", ram_waddr, 0);
    chk("lat_wdata", ram_wdata, 32'hA1);
    tick();
    wr_valid = 0; #1;
    chk("lat_ram_re", ram_re, 1);
    chk("lat_raddr", ram_raddr, 0);
    chk("lat_valid_n1", rd_valid, 0);
    tick(); #1;
    chk("lat_valid_n2", rd_valid, 0);
    tick(); #1;
    chk("lat_valid_n3", rd_valid, 1);
    chk("lat_data", rd_data, 32'hA1);
    rd_ready = 1;
    tick();
    rd_ready = 0;

    // fill with consumer stalled
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1; wr_data = 32'h10 + i; #1;
      chk("fill_wr_ready", wr_ready, 1);
      tick();
    end
    wr_valid = 1; wr_data = 32'h16; #1;
    chk("full_wr_ready", wr_ready, 0);
    chk("full_count", count, 6);
    chk("full_afull", almost_full, 1);
    tick();
    wr_valid = 0;
    tick();

    // drain in order
    rd_ready = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("drain_valid", rd_valid, 1);
      chk("drain_data", rd_data, 32'h10 + i);
      if (i == 0) chk("drain_issue", ram_re, 1);
      tick();
      if (i == 0) chk("drain_wr_ready", wr_ready, 1);
    end
    #1;
    chk("drain_empty", rd_valid, 0);

    // continuous streaming, pointers wrap several times
    for (int c = 0; c < 24; c++) begin
      wr_valid = (c < 20); wr_data = 32'h100 + c; rd_ready = 1; #1;
      chk("stream_valid", rd_valid, (c >= 3) && (c < 23));
      if (c < 20) chk("stream_wr_ready", wr_ready, 1);
      tick();
    end
    chk("stream_drained", q.size(), 0);

    // random traffic
    push_target = pushes_n + 1000;
    pop_target  = pops_n + 1000;
    cyc = 0;
    while (pops_n < pop_target && cyc < 20000) begin
      wr_valid = (pushes_n < push_target) && ($urandom_range(0, 1) == 1);
      wr_data  = $urandom;
      rd_ready = ($urandom_range(0, 1) == 1);
      tick();
      cyc++;
    end
    chk("rand_pops", pops_n, pop_target);
    wr_valid = 0; rd_ready = 0;
    tick();

    // reset with words held
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1; wr_data = 32'hC0 + i; tick();
    end
    wr_valid = 0;
    repeat (3) tick();
    chk("held_count", count, 3);
    rst_n = 0; #1;
    chk("mrst_wr_ready", wr_ready, 1);
    chk("mrst_rd_valid", rd_valid, 0);
    chk("mrst_rd_data", rd_data, 0);
    chk("mrst_count", count, 0);
    chk("mrst_afull", almost_full, 0);
    chk("mrst_ram_we", ram_we, 0);
    chk("mrst_ram_re", ram_re, 0);
    q.delete();
    stall_prev = 0;
    repeat (2) tick();
    rst_n = 1;
    tick();
    chk("post_rst_count", count, 0);
    wr_valid = 1; wr_data = 32'h55;
    tick();
    wr_valid = 0; rd_ready = 1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      if (rd_valid) begin
        chk("post_rst_first", rd_data, 32'h55);
        got = 1;
      end
      tick();
    end
    if (!got) begin
      checks++; errors++;
      $error("FAIL post_rst_timeout observed=no_rd_valid expected=rd_valid");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ram_ctrl.md
Name: sync_fifo_ram_ctrl

Overview:
- Single-clock FIFO controller that acts as the initiator for an external simple dual-port RAM.
- It drives the RAM write port from a valid/ready producer interface and the RAM read port toward a valid/ready consumer interface.
- The RAM has registered read data (1-cycle latency), so a 2-entry output buffer hides that latency and sustains one word per cycle.
- The output is first-word-fall-through: rd_data is valid whenever rd_valid=1.

Parameters:
- DATA_WIDTH, 32, word width.
- DEPTH, 16, RAM entries; must be a power of 2 and at least 2.
- ADDR_WIDTH, $clog2(DEPTH), RAM address width.
- CNT_WIDTH, $clog2(DEPTH+3), width of the occupancy counter.
- AFULL_THRESH, DEPTH-2, almost_full asserts when count >= this value.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  producer has data.
- wr_ready  out  1  controller can accept a write.
- wr_data  in  DATA_WIDTH  producer word.
- rd_valid  out  1  head word present on rd_data.
- rd_ready  in  1  consumer accepts the head word.
- rd_data  out  DATA_WIDTH  head word.
- ram_we  out  1  RAM write enable.
- ram_waddr  out  ADDR_WIDTH  RAM write address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_re  out  1  RAM read issue.
- ram_raddr  out  ADDR_WIDTH  RAM read address.
- ram_rdata  in  DATA_WIDTH  RAM data, valid the cycle after ram_re.
- count  out  CNT_WIDTH  total words held (RAM + in flight + output buffer).
- almost_full  out  1  count >= AFULL_THRESH.

Behaviour:
- **Reset (rst_n=0, asynchronous):**
  - wptr=0, rptr=0, ram_cnt=0, inflight=0, out_cnt=0.
  - Outputs: wr_ready=1, rd_valid=0, rd_data=0, count=0, almost_full=0, ram_we=0, ram_re=0.
  - RAM contents are don't-care afterward; a reset mid-transfer discards all data and in-flight reads, and the ram_rdata of an issued read is ignored.
- **Write path:**
  - wr_ready = (ram_cnt != DEPTH).
  - Push when wr_valid & wr_ready. In that same cycle: ram_we=1, ram_waddr=wptr, ram_wdata=wr_data (combinational pass-through).
  - wptr increments and wraps naturally at DEPTH.
- **Read issue:**
  - ram_re=1 when ram_cnt != 0 and (out_cnt + inflight - pop) < 2, where pop = rd_valid & rd_ready.
  - ram_raddr=rptr; rptr increments and wraps.
  - inflight (0/1) is set for the next cycle by ram_re.
- **Capture:** when inflight=1, ram_rdata is loaded into the output buffer tail at the end of that cycle.
- **Output buffer (2 entries):**
  - rd_data is driven from head register entry 0, and rd_valid = (out_cnt != 0).
  - Pop shifts entry 1 to entry 0.
  - Simultaneous pop and capture is supported.
- **ram_cnt next** = ram_cnt + push - ram_re. Simultaneous push and issue leaves it unchanged.
- **count** is a register = ram_cnt + inflight + out_cnt; the maximum is DEPTH+2. almost_full is registered from the next value of count.
- **RAM address conflicts:** read and write never target the same address in one cycle. A read needs ram_cnt >= 1, so rptr != wptr unless the RAM is full, and then no write is accepted. The RAM read-during-write mode is therefore irrelevant.
- **Latency:** a word pushed in cycle N into an empty FIFO is issued in N+1, returns in N+2, and gives rd_valid=1 in N+3.
- **Throughput:** sustained one push and one pop per cycle with no bubbles once the output buffer is primed.
- **Handshake rules:**
  - rd_data/rd_valid are stable while rd_valid & !rd_ready.
  - wr_ready does not depend combinationally on wr_valid.
  - rd_valid does not depend combinationally on rd_ready.
- **Empty:** pop with rd_valid=0 is ignored. Push when wr_ready=0 is ignored; no state changes.
- **Wrap-around:** pointers are ADDR_WIDTH bits and full/empty come from ram_cnt, not pointer comparison.

Decomposition:
- Package fifo_pkg: function clog2 wrapper, and a ram_req_t struct {we, addr, data} for use by RAM-side instances.
- One sub-module, fifo_out_buf:
  - 2-entry valid/ready output buffer.
  - Inputs: capture strobe, capture data, pop.
  - Outputs: out_cnt, head data.
- The top level holds the pointers, ram_cnt, inflight, issue logic and count.

Test Plan:
- Reset then idle, DEPTH=4: wr_ready=1, rd_valid=0, count=0, ram_re never asserted.
- Push 0xA1 in cycle 1, rd_ready=0: ram_re in cycle 2 with raddr=0; rd_valid=1 with rd_data=0xA1 in cycle 4; count=1 from cycle 2 on.
- Fill with rd_ready=0, pushing 0x10..0x15: all 6 accepted (2 in buffer, 4 in RAM), wr_ready=0 after the 6th, count=6, almost_full=1 once count >= 2.
- Seventh push is held off; then assert rd_ready: rd_data sequence 0x10..0x15 in order; wr_ready returns 1 the cycle after the first RAM read issue.
- Streaming 20 words with wr_valid=rd_ready=1 continuously: one word out per cycle after a 3-cycle startup, pointers wrap 0→3→0 with no loss or duplication.
- Random valid/ready (seed 1) for 1000 words against a scoreboard: data is in order, and rd_data is stable while stalled. An assertion checks ram_we & ram_re never hit the same address.
- Assert rst_n=0 mid-stream with 3 words held: all outputs are at reset values immediately; after release count=0, and the next pushed word 0x55 appears as the first rd_data.
